nios2_debug_vjtag_scan_master: RTL and testbench
================================================

// Module: nios2_debug_vjtag_scan_master
// PURPOSE
//  Initiator side of the CPU debug-slave virtual-JTAG interface: drives tck/tdi/ir_in and the
//  virtual-state strobes (uir/cdr/sdr/udr/rti), and captures tdo. One command is one IR load
//  followed by one DR scan. Used in simulation and on-chip test harnesses in place of the
//  sld_virtual_jtag_basic hub, so the debug slave's tck and sysclk halves can be exercised.
// PARAMETERS
//  DR_WIDTH    38  data-register scan length, in bits (matches the debug slave's sr/jdo width)
//  IR_WIDTH    2   instruction-register width
//  TCK_DIV     2   clk cycles per tck half-period (>=1)
//  RTI_PERIODS 2   tck periods spent in run-test-idle after udr (>=1)
// PORTS
//  clk        in   1         system clock; vji_tck is derived from it
//  reset_n    in   1         asynchronous, active-low reset
//  cmd_valid  in   1         command request
//  cmd_ready  out  1         high when idle; accept on cmd_valid&cmd_ready
//  cmd_ir     in   IR_WIDTH  instruction loaded into vji_ir_in
//  cmd_dr     in   DR_WIDTH  data shifted out on vji_tdi, LSB first
//  rsp_valid  out  1         one-clk pulse: scan complete
//  rsp_dr     out  DR_WIDTH  bits captured from vji_tdo; bit 0 is the first bit shifted in
//  busy       out  1         command in progress (equals ~cmd_ready)
//  vji_tck    out  1         generated tck; a registered data output, never an internal clock
//  vji_tdi    out  1         serial data to the slave
//  vji_tdo    in   1         serial data from the slave
//  vji_ir_in  out  IR_WIDTH  instruction presented to the slave
//  vji_uir/vji_cdr/vji_sdr/vji_udr/vji_rti  out 1  virtual-state strobes, one-hot or all zero
// BEHAVIOUR
//  - Reset values: cmd_ready=1; all other outputs 0, including rsp_dr, vji_ir_in and vji_tck.
//  - Period timing: one "period" is 2*TCK_DIV clk cycles. vji_tck is low for the first TCK_DIV
//    cycles and high for the last TCK_DIV cycles. Strobes, vji_tdi and vji_ir_in change only at
//    period start, the tck-falling point.
//  - FSM: IDLE -> UIR(1 period) -> CDR(1) -> SDR(DR_WIDTH) -> UDR(1) -> RTI(RTI_PERIODS)
//    -> DONE(1 clk) -> IDLE. Each state asserts its own strobe; IDLE and DONE assert no strobe.
//  - vji_tck toggles only in the UIR..RTI states. It is 0 in IDLE and DONE.
//  - Accept (IDLE, cmd_valid=1): latch cmd_ir and cmd_dr into the shift register. In the next
//    clk, enter UIR: cmd_ready=0 and vji_ir_in=cmd_ir. vji_ir_in holds until the next accept.
//  - Shifting in SDR:
//    - vji_tdi = shift register bit 0 during the whole period.
//    - On the clk edge where vji_tck rises, sample vji_tdo into bit DR_WIDTH-1 and shift right.
//    - After DR_WIDTH periods, the shift register holds the captured data.
//    - vji_tdi=0 outside SDR.
//  - DONE: rsp_dr <= captured data; rsp_valid=1 for exactly one clk; cmd_ready=1 in the same clk.
//    rsp_dr holds until the next DONE.
//  - Latency: the clk after the accept edge is cycle 1 of UIR. rsp_valid is high exactly
//    (3+DR_WIDTH+RTI_PERIODS)*2*TCK_DIV + 1 clks after the accept edge.
//  - Back-to-back: cmd_valid high in the DONE clk is accepted, since cmd_ready=1. The next UIR
//    starts the following clk, with no idle tck period.
//  - cmd_valid while busy is ignored; it is not queued.
//  - A cmd_ir equal to the previous value still runs the full UIR period.
//  - Counters: the bit counter spans 0..DR_WIDTH-1 and the phase counter spans 0..TCK_DIV-1.
//    Neither wraps past its terminal count.
//  - Reset mid-command: abort immediately. All outputs return to reset values, with no
//    rsp_valid and no partial rsp_dr update.
// TESTING
//  1. Assert reset_n=0 at an arbitrary point -> cmd_ready=1; all outputs, tck and strobes 0 at once.
//  2. Defaults. cmd_ir=2'b01, cmd_dr=38'h2A_AAAA_AAAA; a tdo model returns 38'h15_5555_5555 LSB first
//     -> tdi sequence 0,1,0,1,...; rsp_dr=38'h15_5555_5555; vji_ir_in=2'b01.
//  3. Defaults -> rsp_valid exactly 173 clks after accept; vji_uir high for 4 clks; vji_sdr high
//     for 152 clks; 43 rising tck edges per command.
//  4. cmd_valid held high for 2 commands -> second accepted in the first's DONE clk; its uir
//     strobe starts the next clk.
//  5. Reset pulse at SDR bit 10 -> no rsp_valid; next command completes with correct rsp_dr.
//  6. TCK_DIV=1, DR_WIDTH=8, RTI_PERIODS=1 -> tck toggles every clk; rsp_valid 25 clks after
//     accept; 8-bit loopback correct.

Source files
------------

// File: rtl/nios2_debug_vjtag_scan_master.sv
// Virtual-JTAG initiator for the CPU debug slave: one IR load then one DR scan per command,
// with tck and the virtual-state strobes generated as registered outputs from clk.
module nios2_debug_vjtag_scan_master #(
   parameter int unsigned DR_WIDTH    = 38,
   parameter int unsigned IR_WIDTH    = 2,
   parameter int unsigned TCK_DIV     = 2,
   parameter int unsigned RTI_PERIODS = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [IR_WIDTH-1:0] cmd_ir,
   input  logic [DR_WIDTH-1:0] cmd_dr,
   output logic                rsp_valid,
   output logic [DR_WIDTH-1:0] rsp_dr,
   output logic                busy,
   output logic                vji_tck,
   output logic                vji_tdi,
   input  logic                vji_tdo,
   output logic [IR_WIDTH-1:0] vji_ir_in,
   output logic                vji_uir,
   output logic                vji_cdr,
   output logic                vji_sdr,
   output logic                vji_udr,
   output logic                vji_rti
);

   localparam int unsigned PH_W    = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
   localparam int unsigned CNT_MAX = (DR_WIDTH > RTI_PERIODS) ? DR_WIDTH : RTI_PERIODS;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(TCK_DIV - 1);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DR_WIDTH - 1);
   localparam logic [CNT_W-1:0] RTI_LAST = CNT_W'(RTI_PERIODS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [PH_W-1:0]     phase_q, phase_d;
   logic                half_q, half_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DR_WIDTH-1:0] sr_q, sr_d;

   logic                half_end, per_end, rise, active_d;
   logic                ready_d, rsp_valid_d, tck_d, tdi_d;
   logic [DR_WIDTH-1:0] rsp_dr_d;
   logic [IR_WIDTH-1:0] ir_d;

   // Next-state, counters, shift register and next output values
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      half_d      = half_q;
      cnt_d       = cnt_q;
      sr_d        = sr_q;
      ir_d        = vji_ir_in;
      tdi_d       = vji_tdi;
      rsp_dr_d    = rsp_dr;
      half_end    = (phase_q == PH_LAST);
      per_end     = half_q & half_end;
      rise        = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (cmd_valid) begin
               state_d = S_UIR;
               phase_d = '0;
               half_d  = 1'b0;
               cnt_d   = '0;
               sr_d    = cmd_dr;
               ir_d    = cmd_ir;
            end
         end
         default: begin
            rise = ~half_q & half_end;
            if (half_end) begin
               phase_d = '0;
               half_d  = ~half_q;
            end else begin
               phase_d = phase_q + PH_W'(1);
            end
            if (per_end) begin
               case (state_q)
                  S_UIR: state_d = S_CDR;
                  S_CDR: begin
                     state_d = S_SDR;
                     cnt_d   = '0;
                  end
                  S_SDR: begin
                     if (cnt_q == BIT_LAST) begin
                        state_d = S_UDR;
                        cnt_d   = '0;
                     end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                     end
                  end
                  S_UDR: begin
                     state_d = S_RTI;
                     cnt_d   = '0;
                  end
                  S_RTI: begin
                     if (cnt_q == RTI_LAST) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                     end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                     end
                  end
                  default: state_d = S_IDLE;
               endcase
            end
            // capture tdo on the clk edge that raises tck
            if (rise && (state_q == S_SDR)) begin
               sr_d = {vji_tdo, sr_q[DR_WIDTH-1:1]};
            end
         end
      endcase

      active_d    = (state_d != S_IDLE) && (state_d != S_DONE);
      ready_d     = ~active_d;
      tck_d       = active_d & half_d;
      rsp_valid_d = (state_d == S_DONE);

      // tdi only moves at period start; the mid-period shift must not disturb it
      if (state_d != S_SDR) begin
         tdi_d = 1'b0;
      end else if (per_end) begin
         tdi_d = sr_q[0];
      end

      if (state_d == S_DONE) begin
         rsp_dr_d = sr_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         phase_q   <= '0;
         half_q    <= 1'b0;
         cnt_q     <= '0;
         sr_q      <= '0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_dr    <= '0;
         vji_tck   <= 1'b0;
         vji_tdi   <= 1'b0;
         vji_ir_in <= '0;
         vji_uir   <= 1'b0;
         vji_cdr   <= 1'b0;
         vji_sdr   <= 1'b0;
         vji_udr   <= 1'b0;
         vji_rti   <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         half_q    <= half_d;
         cnt_q     <= cnt_d;
         sr_q      <= sr_d;
         cmd_ready <= ready_d;
         busy      <= ~ready_d;
         rsp_valid <= rsp_valid_d;
         rsp_dr    <= rsp_dr_d;
         vji_tck   <= tck_d;
         vji_tdi   <= tdi_d;
         vji_ir_in <= ir_d;
         vji_uir   <= (state_d == S_UIR);
         vji_cdr   <= (state_d == S_CDR);
         vji_sdr   <= (state_d == S_SDR);
         vji_udr   <= (state_d == S_UDR);
         vji_rti   <= (state_d == S_RTI);
      end
   end

endmodule

// File: tb/tb_nios2_debug_vjtag_scan_master.sv
// Bench for the vJTAG scan master: default-parameter DUT with a tdo pattern model, plus a
// TCK_DIV=1/DR_WIDTH=8 instance in tdi->tdo loopback.
module tb_nios2_debug_vjtag_scan_master;

   typedef struct {
      logic [1:0]  ir;
      logic [37:0] dr;
      logic [37:0] pat;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   // default instance
   logic        cmd_valid, cmd_ready, rsp_valid, busy;
   logic [1:0]  cmd_ir, vji_ir_in;
   logic [37:0] cmd_dr, rsp_dr;
   logic        vji_tck, vji_tdi, vji_tdo;
   logic        vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

   nios2_debug_vjtag_scan_master dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
      .rsp_valid(rsp_valid), .rsp_dr(rsp_dr), .busy(busy),
      .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in),
      .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr),
      .vji_rti(vji_rti)
   );

   // small fast instance, tdo looped back from tdi
   logic        cmd_valid_s, cmd_ready_s, rsp_valid_s, busy_s;
   logic [1:0]  cmd_ir_s, ir_in_s;
   logic [7:0]  cmd_dr_s, rsp_dr_s;
   logic        tck_s, tdi_s;
   logic        uir_s, cdr_s, sdr_s, udr_s, rti_s;

   nios2_debug_vjtag_scan_master #(
      .DR_WIDTH(8), .IR_WIDTH(2), .TCK_DIV(1), .RTI_PERIODS(1)
   ) dut_s (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid_s), .cmd_ready(cmd_ready_s), .cmd_ir(cmd_ir_s), .cmd_dr(cmd_dr_s),
      .rsp_valid(rsp_valid_s), .rsp_dr(rsp_dr_s), .busy(busy_s),
      .vji_tck(tck_s), .vji_tdi(tdi_s), .vji_tdo(tdi_s), .vji_ir_in(ir_in_s),
      .vji_uir(uir_s), .vji_cdr(cdr_s), .vji_sdr(sdr_s), .vji_udr(udr_s), .vji_rti(rti_s)
   );

   // tdo model: restarts on CDR, presents pattern LSB first, advances after each SDR tck rise
   logic [37:0] pat_next = '0;
   logic [37:0] pat_cur  = '0;
   int          idx      = 0;
   assign vji_tdo = (idx < 38) ? pat_cur[idx[5:0]] : 1'b0;

   always @(posedge vji_tck) begin
      if (vji_cdr) begin
         idx     <= 0;
         pat_cur <= pat_next;
      end else if (vji_sdr) begin
         idx <= idx + 1;
      end
   end

   int checks = 0;
   int errors = 0;
   vec_t        q[$];
   logic [7:0]  q_s[$];
   vec_t        vecs[4];

   int          cyc = 0, acc_cyc = 0, acc_cyc_s = 0;
   int          uir_cnt = 0, sdr_cnt = 0, rise_cnt = 0, sdr_rise = 0;
   logic [37:0] tdi_cap = '0;
   logic        tck_prev = 1'b0, tck_prev_s = 1'b0, busy_prev_s = 1'b0;
   logic        mon_acc = 1'b0, mon_acc_s = 1'b0, last_acc_rsp = 1'b0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Mid-cycle sampling of both DUTs and scoreboard pops
   task automatic monitor();
      vec_t       e;
      logic [7:0] e8;
      logic       tck_exp;
      cyc++;
      if (!reset_n) begin
         chk("rst_ready", 64'(cmd_ready), 64'(1));
         chk("rst_outs", 64'({busy, rsp_valid, rsp_dr, vji_tck, vji_tdi, vji_ir_in,
                              vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'(0));
         chk("rst_ready_s", 64'(cmd_ready_s), 64'(1));
         chk("rst_outs_s", 64'({busy_s, rsp_valid_s, rsp_dr_s, tck_s, tdi_s, ir_in_s,
                                uir_s, cdr_s, sdr_s, udr_s, rti_s}), 64'(0));
      end

      if (rsp_valid) begin
         if (q.size() == 0) begin
            chk("rsp_unexpected", 64'(q.size()), 64'(1));
         end else begin
            e = q.pop_front();
            chk("rsp_dr", 64'(rsp_dr), 64'(e.pat));
            chk("ir_in", 64'(vji_ir_in), 64'(e.ir));
            chk("tdi_seq", 64'(tdi_cap), 64'(e.dr));
            chk("latency", 64'(cyc - acc_cyc), 64'(173));
            chk("uir_clks", 64'(uir_cnt), 64'(4));
            chk("sdr_clks", 64'(sdr_cnt), 64'(152));
            chk("tck_rises", 64'(rise_cnt), 64'(43));
            chk("ready_in_done", 64'(cmd_ready), 64'(1));
         end
      end
      if (vji_uir) uir_cnt++;
      if (vji_sdr) sdr_cnt++;
      if (vji_tck && !tck_prev) begin
         rise_cnt++;
         if (vji_sdr) begin
            if (sdr_rise < 38) tdi_cap[sdr_rise[5:0]] = vji_tdi;
            sdr_rise++;
         end
      end
      tck_prev = vji_tck;
      mon_acc  = cmd_valid & cmd_ready;
      if (mon_acc) begin
         acc_cyc      = cyc;
         last_acc_rsp = rsp_valid;
         uir_cnt      = 0;
         sdr_cnt      = 0;
         rise_cnt     = 0;
         sdr_rise     = 0;
         tdi_cap      = '0;
      end

      if (rsp_valid_s) begin
         if (q_s.size() == 0) begin
            chk("s_rsp_unexpected", 64'(q_s.size()), 64'(1));
         end else begin
            e8 = q_s.pop_front();
            chk("s_rsp_dr", 64'(rsp_dr_s), 64'(e8));
            chk("s_latency", 64'(cyc - acc_cyc_s), 64'(25));
         end
      end
      if (busy_s) begin
         tck_exp = busy_prev_s ? ~tck_prev_s : 1'b0;
         chk("s_tck", 64'(tck_s), 64'(tck_exp));
      end
      tck_prev_s  = tck_s;
      busy_prev_s = busy_s;
      mon_acc_s   = cmd_valid_s & cmd_ready_s;
      if (mon_acc_s) acc_cyc_s = cyc;
   endtask

   // Sample mid-cycle, then move to just after the next rising edge for driving
   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_acc();
      int n = 0;
      do begin
         tick();
         n++;
      end while (!mon_acc && n < 1000);
      chk("accept", 64'(mon_acc), 64'(1));
   endtask

   task automatic send(input vec_t v);
      cmd_ir    = v.ir;
      cmd_dr    = v.dr;
      pat_next  = v.pat;
      cmd_valid = 1'b1;
      q.push_back(v);
      wait_acc();
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || q_s.size() != 0) && n < 2000) begin
         tick();
         n++;
      end
      chk("drain", 64'(q.size() + q_s.size()), 64'(0));
      q.delete();
      q_s.delete();
   endtask

   initial begin
      vecs[0] = '{2'b01, 38'h2A_AAAA_AAAA, 38'h15_5555_5555};
      vecs[1] = '{2'b01, 38'h00_0000_0000, 38'h3F_FFFF_FFFF};
      vecs[2] = '{2'b10, 38'h3F_FFFF_FFFF, 38'h00_0000_0000};
      vecs[3] = '{2'b11, 38'h21_2345_6789, 38'h1E_DCBA_9876};

      reset_n     = 1'b0;
      cmd_valid   = 1'b0;
      cmd_ir      = '0;
      cmd_dr      = '0;
      cmd_valid_s = 1'b0;
      cmd_ir_s    = '0;
      cmd_dr_s    = '0;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
      chk("ready_after_reset", 64'(cmd_ready), 64'(1));

      // table-driven commands; vecs[1] repeats the previous ir
      for (int i = 0; i < 4; i++) begin
         send(vecs[i]);
         drain();
      end

      // back-to-back: valid held, second command changed while first is busy
      cmd_ir    = vecs[0].ir;
      cmd_dr    = vecs[0].dr;
      pat_next  = vecs[0].pat;
      cmd_valid = 1'b1;
      q.push_back(vecs[0]);
      wait_acc();
      for (int n = 0; n < 100 && !vji_sdr; n++) tick();
      cmd_ir   = vecs[2].ir;
      cmd_dr   = vecs[2].dr;
      pat_next = vecs[2].pat;
      q.push_back(vecs[2]);
      wait_acc();
      chk("b2b_acc_in_done", 64'(last_acc_rsp), 64'(1));
      cmd_valid = 1'b0;
      chk("b2b_uir_next", 64'(vji_uir), 64'(1));
      drain();

      // asynchronous reset at SDR bit 10
      send(vecs[3]);
      for (int n = 0; n < 500 && !(vji_sdr && sdr_rise >= 10); n++) tick();
      chk("reached_sdr10", 64'(sdr_rise), 64'(10));
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_ready", 64'(cmd_ready), 64'(1));
      chk("arst_outs", 64'({busy, rsp_valid, rsp_dr, vji_tck, vji_tdi, vji_ir_in,
                            vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'(0));
      q.delete();
      @(posedge clk);
      #1;
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (3) tick();
      chk("no_rsp_after_abort", 64'({rsp_valid, rsp_dr}), 64'(0));
      send(vecs[1]);
      drain();

      // fast instance, loopback
      for (int i = 0; i < 3; i++) begin
         cmd_ir_s    = 2'(i);
         cmd_dr_s    = (i == 0) ? 8'hA5 : (i == 1) ? 8'h3C : 8'h81;
         cmd_valid_s = 1'b1;
         q_s.push_back(cmd_dr_s);
         for (int n = 0; n < 100; n++) begin
            tick();
            if (mon_acc_s) break;
         end
         chk("s_accept", 64'(mon_acc_s), 64'(1));
         cmd_valid_s = 1'b0;
         drain();
      end
      tick();
      chk("s_idle_tck", 64'({tck_s, busy_s}), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
